// File: rtl/befehls_holer.sv
// Instruction fetch unit: holds the PC, fetches one word per request and
// allows exactly one PC update (increment or jump) per instruction.
module befehls_holer #(
  parameter logic [31:0] START_ADRESSE = 32'h0000_0000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        LoadBefehlSignal,
  input  logic        PCSignal,
  input  logic        PCSprungSignal,
  input  logic [31:0] SprungZiel,
  input  logic [31:0] MemDaten,
  input  logic        MemBereit,
  output logic [31:0] MemAdresse,
  output logic        MemLesen,
  output logic [31:0] Befehl,
  output logic        BefehlGeladen,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4
);

  typedef enum logic [1:0] {
    LEERLAUF = 2'd0,
    WARTEN   = 2'd1,
    FERTIG   = 2'd2
  } zustand_t;

  localparam logic [31:0] WORT_MASKE = 32'hFFFF_FFFC;

  zustand_t    zustand, zustandNext;
  logic [31:0] pcReg, pcNext;
  logic        aktualisiert, aktualisiertNext;
  logic        pcUpdate;
  logic        befehlLaden;
  logic        memLesenNext, geladenNext;

  // PC writes are blocked while a read is outstanding so the address the
  // memory sees cannot move under it.
  assign pcUpdate = PCSignal && !aktualisiert && (zustand != WARTEN);

  always_comb begin
    zustandNext = zustand;
    befehlLaden = 1'b0;
    case (zustand)
      LEERLAUF: if (LoadBefehlSignal && !pcUpdate) zustandNext = WARTEN;
      WARTEN: begin
        if (MemBereit) begin
          zustandNext = FERTIG;
          befehlLaden = 1'b1;
        end
      end
      FERTIG:   zustandNext = LEERLAUF;
      default:  zustandNext = LEERLAUF;
    endcase
    memLesenNext = (zustandNext == WARTEN);
    geladenNext  = (zustandNext == FERTIG);
  end

  always_comb begin
    aktualisiertNext = aktualisiert;
    if ((zustand == LEERLAUF) && (zustandNext == WARTEN))
      aktualisiertNext = 1'b0;
    else if (pcUpdate)
      aktualisiertNext = 1'b1;
  end

  // Jump targets are forced word aligned; the +4 path wraps modulo 2^32.
  always_comb begin
    pcNext = pcReg;
    if (pcUpdate)
      pcNext = PCSprungSignal ? (SprungZiel & WORT_MASKE) : (pcReg + 32'd4);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      zustand       <= LEERLAUF;
      pcReg         <= START_ADRESSE & WORT_MASKE;
      aktualisiert  <= 1'b0;
      Befehl        <= 32'h0;
      MemLesen      <= 1'b0;
      BefehlGeladen <= 1'b0;
    end else begin
      zustand       <= zustandNext;
      pcReg         <= pcNext;
      aktualisiert  <= aktualisiertNext;
      MemLesen      <= memLesenNext;
      BefehlGeladen <= geladenNext;
      if (befehlLaden) Befehl <= MemDaten;
    end
  end

  assign PC         = pcReg;
  assign MemAdresse = pcReg;
  assign PCPlus4    = pcReg + 32'd4;

endmodule

// File: tb/tb_befehls_holer.sv
// Directed and randomized checks of befehls_holer against a PC/fetch model.
module tb_befehls_holer;
  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        LoadBefehlSignal = 1'b0;
  logic        PCSignal = 1'b0;
  logic        PCSprungSignal = 1'b0;
  logic [31:0] SprungZiel = 32'h0;
  logic [31:0] MemDaten = 32'h0;
  logic        MemBereit = 1'b0;
  logic [31:0] MemAdresse, Befehl, PC, PCPlus4;
  logic        MemLesen, BefehlGeladen;

  int checks = 0;
  int errors = 0;
  logic [31:0] modelPc;
  logic [31:0] modelBefehl;

  befehls_holer dut (
    .Clock(Clock), .Reset(Reset), .LoadBefehlSignal(LoadBefehlSignal),
    .PCSignal(PCSignal), .PCSprungSignal(PCSprungSignal), .SprungZiel(SprungZiel),
    .MemDaten(MemDaten), .MemBereit(MemBereit), .MemAdresse(MemAdresse),
    .MemLesen(MemLesen), .Befehl(Befehl), .BefehlGeladen(BefehlGeladen),
    .PC(PC), .PCPlus4(PCPlus4)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // One complete fetch from idle: request for one cycle, `waits` cycles
  // without MemBereit, then data arrives.
  task automatic fetch(input logic [31:0] data, input int waits);
    logic [31:0] adr;
    adr = modelPc;
    LoadBefehlSignal = 1'b1;
    MemBereit = 1'b0;
    chk("idle_memlesen", {31'b0, MemLesen}, 32'd0);
    step();
    LoadBefehlSignal = 1'b0;
    chk("wait_memlesen", {31'b0, MemLesen}, 32'd1);
    chk("wait_adresse", MemAdresse, adr);
    chk("wait_geladen", {31'b0, BefehlGeladen}, 32'd0);
    for (int i = 0; i < waits; i++) begin
      step();
      chk("stall_memlesen", {31'b0, MemLesen}, 32'd1);
      chk("stall_adresse", MemAdresse, adr);
      chk("stall_befehl", Befehl, modelBefehl);
    end
    MemBereit = 1'b1;
    MemDaten = data;
    step();
    MemBereit = 1'b0;
    MemDaten = ~data;
    modelBefehl = data;
    chk("done_geladen", {31'b0, BefehlGeladen}, 32'd1);
    chk("done_memlesen", {31'b0, MemLesen}, 32'd0);
    chk("done_befehl", Befehl, modelBefehl);
    step();
    chk("after_geladen", {31'b0, BefehlGeladen}, 32'd0);
    chk("after_befehl", Befehl, modelBefehl);
  endtask

  // PC update window held for `cycles` cycles; only the first one counts.
  task automatic pcWindow(input int cycles, input logic jump, input logic [31:0] ziel);
    PCSignal = 1'b1;
    PCSprungSignal = jump;
    SprungZiel = ziel;
    chk("pcplus4_pre", PCPlus4, modelPc + 32'd4);
    modelPc = jump ? {ziel[31:2], 2'b00} : modelPc + 32'd4;
    for (int i = 0; i < cycles; i++) begin
      step();
      chk("pc_window", PC, modelPc);
      chk("pc_align", {30'b0, PC[1:0]}, 32'd0);
    end
    PCSignal = 1'b0;
    PCSprungSignal = 1'b0;
    step();
    chk("pc_hold", PC, modelPc);
    chk("pcplus4", PCPlus4, modelPc + 32'd4);
  endtask

  initial begin
    modelPc = 32'h0;
    modelBefehl = 32'h0;
    #2 Reset = 1'b0;
    #1;
    chk("rst_pc", PC, 32'h0);
    chk("rst_befehl", Befehl, 32'h0);
    chk("rst_memlesen", {31'b0, MemLesen}, 32'd0);
    chk("rst_geladen", {31'b0, BefehlGeladen}, 32'd0);
    step();
    Reset = 1'b1;
    step();

    // first fetch reads START_ADRESSE, pulse 2 cycles after request
    fetch(32'h1234_5678, 0);
    chk("first_adr_zero", modelPc, MemAdresse);

    // jump with misaligned target to 0x100, then three-cycle increment window
    pcWindow(1, 1'b1, 32'h0000_0101);
    chk("jump_100", PC, 32'h0000_0100);
    fetch(32'hA5A5_0001, 1);
    pcWindow(3, 1'b0, 32'h0);
    chk("single_inc", PC, 32'h0000_0104);
    fetch(32'hA5A5_0002, 0);

    pcWindow(2, 1'b1, 32'h0000_0203);
    chk("jump_200", PC, 32'h0000_0200);
    chk("jump_200_p4", PCPlus4, 32'h0000_0204);
    fetch(32'hA5A5_0003, 0);

    // wrap-around
    pcWindow(1, 1'b1, 32'hFFFF_FFFC);
    fetch(32'hA5A5_0004, 0);
    chk("wrap_p4_pre", PCPlus4, 32'h0);
    pcWindow(1, 1'b0, 32'h0);
    chk("wrap_pc", PC, 32'h0);
    fetch(32'hA5A5_0005, 0);

    // long stall with request dropped
    fetch(32'hCAFE_F00D, 5);

    // PC update and fetch request in the same idle cycle: update first
    PCSignal = 1'b1;
    PCSprungSignal = 1'b1;
    SprungZiel = 32'h0000_0840;
    LoadBefehlSignal = 1'b1;
    step();
    modelPc = 32'h0000_0840;
    chk("coin_no_read", {31'b0, MemLesen}, 32'd0);
    chk("coin_pc", PC, modelPc);
    SprungZiel = 32'h0000_0F00;
    step();
    PCSignal = 1'b0;
    PCSprungSignal = 1'b0;
    LoadBefehlSignal = 1'b0;
    chk("coin_read", {31'b0, MemLesen}, 32'd1);
    chk("coin_adr", MemAdresse, modelPc);
    MemBereit = 1'b1;
    MemDaten = 32'h0BAD_BEEF;
    step();
    MemBereit = 1'b0;
    modelBefehl = 32'h0BAD_BEEF;
    chk("coin_geladen", {31'b0, BefehlGeladen}, 32'd1);
    chk("coin_befehl", Befehl, modelBefehl);
    step();

    // randomized instructions
    for (int n = 0; n < 25; n++) begin
      pcWindow(int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), $urandom);
      fetch($urandom, int'($urandom_range(0, 3)));
    end

    // reset in the middle of a read
    LoadBefehlSignal = 1'b1;
    step();
    LoadBefehlSignal = 1'b0;
    chk("mid_read", {31'b0, MemLesen}, 32'd1);
    Reset = 1'b0;
    #1;
    modelPc = 32'h0;
    modelBefehl = 32'h0;
    chk("mid_rst_memlesen", {31'b0, MemLesen}, 32'd0);
    chk("mid_rst_pc", PC, modelPc);
    chk("mid_rst_befehl", Befehl, modelBefehl);
    step();
    Reset = 1'b1;
    MemBereit = 1'b1;
    MemDaten = 32'hDEAD_0001;
    step();
    chk("late_bereit_geladen", {31'b0, BefehlGeladen}, 32'd0);
    chk("late_bereit_memlesen", {31'b0, MemLesen}, 32'd0);
    step();
    MemBereit = 1'b0;
    chk("late_bereit_geladen2", {31'b0, BefehlGeladen}, 32'd0);
    chk("late_bereit_befehl", Befehl, modelBefehl);
    fetch(32'h7777_1111, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
